// File: rtl/bus_pkg.sv
// bus_pkg: shared types and helpers for bs_gnrtr_n_rbtr bus endpoints.
//   BUS_PKT_T(W)  : macro giving a W-bit packet type (pkt_t in users).
//   ID_W, BCST_ID : destination-ID width and broadcast ID.
//   get_id()      : extracts the destination ID from the top ID_W bits.
//   sat_inc16()   : 16-bit saturating increment for statistics.
//   ep_stat_t     : endpoint statistics bundle {rx, drop, misroute}.
//   fifo_state_t  : receive FIFO occupancy state.

`define BUS_PKT_T(W) logic [(W)-1:0]

package bus_pkg;

  localparam int              ID_W      = 8;
  localparam logic [ID_W-1:0] BCST_ID   = 8'hFF;
  // Widest packet get_id() accepts; callers zero-extend into this.
  localparam int              PKT_MAX_W = 256;

  typedef struct packed {
    logic [15:0] rx;
    logic [15:0] drop;
    logic [15:0] misroute;
  } ep_stat_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_t;

  // A shift keeps the select width constant for any packet width.
  function automatic logic [ID_W-1:0] get_id(input logic [PKT_MAX_W-1:0] pkt,
                                             input int unsigned          pkt_w);
    logic [PKT_MAX_W-1:0] shifted;
    shifted = pkt >> (pkt_w - ID_W);
    return shifted[ID_W-1:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bus_rx_endpoint_if.sv
// bus_rx_endpoint_if: bus delivery and local-consumer handshake.
//   push/D_push       : bus delivery strobe and packet (bus -> endpoint).
//   rd_valid/rd_data  : head packet offered to the consumer (endpoint -> consumer).
//   rd_ready          : consumer accepts the head (consumer -> endpoint).
// master = bus/consumer side, slave = endpoint side.

interface bus_rx_endpoint_if #(
  parameter int pckg_sz = 16
);
  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               rd_valid;
  logic [pckg_sz-1:0] rd_data;
  logic               rd_ready;

  modport master (
    output push, D_push, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  push, D_push, rd_ready,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with registered count/state.
//   clk, reset  : clock, synchronous active-high reset.
//   wr_en_i     : write request; honoured when not full or when popping.
//   wr_data_i   : write data.
//   rd_en_i     : pop request; ignored while empty.
//   rd_valid_o  : head valid; rd_data_o : head data (0 when empty).
//   count_o, full_o, empty_o : post-edge occupancy.

module sync_fifo
  import bus_pkg::*;
#(
  parameter  int width = 16,
  parameter  int depth = 8,
  localparam int PTR_W = $clog2(depth),
  localparam int CNT_W = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic             rd_valid_o,
  output logic [width-1:0] rd_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [width-1:0] mem_q [depth];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  fifo_state_t      state_q, state_d;
  logic             wr_ok, rd_ok;

  assign rd_ok = rd_en_i & (state_q != FIFO_EMPTY);
  // A write into a full FIFO is legal when the head leaves in the same cycle.
  assign wr_ok = wr_en_i & ((state_q != FIFO_FULL) | rd_ok);

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (count_d == '0)                state_d = FIFO_EMPTY;
    else if (count_d == CNT_W'(depth)) state_d = FIFO_FULL;
    else                              state_d = FIFO_PARTIAL;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= FIFO_EMPTY;
    end else begin
      // Power-of-two depth: pointers wrap modulo depth naturally.
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // NOTE: storage is not reset; an entry is only visible after it is written,
  // so clearing the pointers and state is enough.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_valid_o = (state_q != FIFO_EMPTY);
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;
  assign full_o     = (state_q == FIFO_FULL);
  assign empty_o    = (state_q == FIFO_EMPTY);

endmodule

// File: rtl/bus_rx_endpoint.sv
// bus_rx_endpoint: device-side receive endpoint of the bs_gnrtr_n_rbtr bus.
// Filters delivered packets by destination ID (dev_id or broadcast), buffers
// accepted packets in a FWFT FIFO and keeps saturating statistics.
//   clk, reset   : clock, synchronous active-high reset.
//   bus (slave)  : push/D_push in, rd_valid/rd_data out, rd_ready in.
//   count/full/empty : FIFO occupancy.
//   ovf          : sticky, a matching packet was dropped.
//   clr_stat     : clears ovf and counters (wins over same-cycle events).
//   rx_cnt/drop_cnt/misroute_cnt : saturating 16-bit statistics.

module bus_rx_endpoint
  import bus_pkg::*;
#(
  parameter  int              drvrs   = 4,
  parameter  int              pckg_sz = 16,
  parameter  int              depth   = 8,
  parameter  int              dev_id  = 0,
  parameter  logic [ID_W-1:0] bcst    = BCST_ID,
  localparam int              CNT_W   = $clog2(depth + 1)
) (
  input  logic               clk,
  input  logic               reset,
  bus_rx_endpoint_if.slave   bus,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               ovf,
  input  logic               clr_stat,
  output logic [15:0]        rx_cnt,
  output logic [15:0]        drop_cnt,
  output logic [15:0]        misroute_cnt
);

  if (dev_id < 0 || dev_id >= drvrs) begin : g_bad_dev_id
    $error("bus_rx_endpoint: dev_id must be in [0, drvrs)");
  end
  if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("bus_rx_endpoint: depth must be a power of two and at least 2");
  end

  typedef `BUS_PKT_T(pckg_sz) pkt_t;

  logic [ID_W-1:0] id;
  logic            match, rd_valid, rd_fire;
  logic            accept, drop, misroute;
  pkt_t            head;
  ep_stat_t        stat_q, stat_d;
  logic            ovf_q, ovf_d;

  assign id      = get_id(PKT_MAX_W'(bus.D_push), pckg_sz);
  assign match   = (id == ID_W'(dev_id)) || (id == bcst);
  assign rd_fire = rd_valid & bus.rd_ready;

  // Nothing is accepted or counted in a reset cycle.
  assign accept   = ~reset & bus.push &  match & (~full | rd_fire);
  assign drop     = ~reset & bus.push &  match &   full & ~rd_fire;
  assign misroute = ~reset & bus.push & ~match;

  sync_fifo #(
    .width (pckg_sz),
    .depth (depth)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (accept),
    .wr_data_i  (bus.D_push),
    .rd_en_i    (bus.rd_ready),
    .rd_valid_o (rd_valid),
    .rd_data_o  (head),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = head;

  always_comb begin
    stat_d = stat_q;
    ovf_d  = ovf_q;
    if (clr_stat) begin
      stat_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (accept)   stat_d.rx       = sat_inc16(stat_q.rx);
      if (misroute) stat_d.misroute = sat_inc16(stat_q.misroute);
      if (drop) begin
        stat_d.drop = sat_inc16(stat_q.drop);
        ovf_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      stat_q <= stat_d;
      ovf_q  <= ovf_d;
    end
  end

  assign rx_cnt       = stat_q.rx;
  assign drop_cnt     = stat_q.drop;
  assign misroute_cnt = stat_q.misroute;
  assign ovf          = ovf_q;

  a_no_push_in_reset : assert property (@(posedge clk) reset |-> !accept);
  a_count_bound      : assert property (@(posedge clk) count <= CNT_W'(depth));
  a_rd_data_stable   : assert property (@(posedge clk) disable iff (reset)
                                        (rd_valid && !bus.rd_ready) |=> $stable(head));

endmodule

// File: tb/tb_bus_rx_endpoint.sv
// tb_bus_rx_endpoint: directed, table-driven bench for bus_rx_endpoint
// (pckg_sz=16, depth=4, dev_id=2). Inputs change on the falling edge and
// outputs are compared on the next falling edge, i.e. after one rising edge.

module tb_bus_rx_endpoint;
  import bus_pkg::*;

  localparam int PKT_W  = 16;
  localparam int DEPTH  = 4;
  localparam int DEV_ID = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             clr_stat;
  logic [CNT_W-1:0] count;
  logic             full, empty, ovf;
  logic [15:0]      rx_cnt, drop_cnt, misroute_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bus_rx_endpoint_if #(.pckg_sz(PKT_W)) bus_if ();

  bus_rx_endpoint #(
    .drvrs   (4),
    .pckg_sz (PKT_W),
    .depth   (DEPTH),
    .dev_id  (DEV_ID),
    .bcst    (8'hFF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .ovf          (ovf),
    .clr_stat     (clr_stat),
    .rx_cnt       (rx_cnt),
    .drop_cnt     (drop_cnt),
    .misroute_cnt (misroute_cnt)
  );

  typedef struct {
    logic        rst, push;
    logic [15:0] d;
    logic        rdy, clr;
    logic        rv;
    logic [15:0] rdat;
    int          cnt;
    logic        full, empty, ovf;
    ep_stat_t    st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, push, input logic [15:0] d,
                              input logic rdy, clr, rv, input logic [15:0] rdat,
                              input int cnt, input logic f, e, o,
                              input int rx, dr, mis);
    vec_t v;
    v.rst = rst; v.push = push; v.d = d; v.rdy = rdy; v.clr = clr;
    v.rv = rv; v.rdat = rdat; v.cnt = cnt; v.full = f; v.empty = e; v.ovf = o;
    v.st.rx = 16'(rx); v.st.drop = 16'(dr); v.st.misroute = 16'(mis);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic rst, push, input logic [15:0] d, input logic rdy, clr);
    reset = rst; bus_if.push = push; bus_if.D_push = d;
    bus_if.rd_ready = rdy; clr_stat = clr;
  endtask

  task automatic expect_all(input string tag, input logic rv, input logic [15:0] rdat,
                            input int cnt, input logic f, e, o, input ep_stat_t st);
    check({tag, ".rd_valid"}, 32'(bus_if.rd_valid), 32'(rv));
    check({tag, ".rd_data"},  32'(bus_if.rd_data),  32'(rdat));
    check({tag, ".count"},    32'(count),           32'(cnt));
    check({tag, ".full"},     32'(full),            32'(f));
    check({tag, ".empty"},    32'(empty),           32'(e));
    check({tag, ".ovf"},      32'(ovf),             32'(o));
    check({tag, ".rx_cnt"},   32'(rx_cnt),          32'(st.rx));
    check({tag, ".drop_cnt"}, 32'(drop_cnt),        32'(st.drop));
    check({tag, ".misroute"}, 32'(misroute_cnt),    32'(st.misroute));
  endtask

  // One step: apply inputs, let one rising edge pass, compare on the falling edge.
  task automatic step(input string tag, input logic rst, push, input logic [15:0] d,
                      input logic rdy, clr, rv, input logic [15:0] rdat,
                      input int cnt, input logic f, e, o, input int rx, dr, mis);
    ep_stat_t st;
    st.rx = 16'(rx); st.drop = 16'(dr); st.misroute = 16'(mis);
    drive(rst, push, d, rdy, clr);
    @(negedge clk);
    expect_all(tag, rv, rdat, cnt, f, e, o, st);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : main
    //             rst push d        rdy clr | rv rdat    cnt f e o  rx dr mis
    // Reset state
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0,  0, 16'h0000, 0, 0, 1, 0, 0, 0, 0));
    // 1: single packet, immediate read
    vecs.push_back(mk(0, 1, 16'h02AB, 1, 0,  1, 16'h02AB, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0,  0, 16'h0000, 0, 0, 1, 0, 1, 0, 0));
    // 2: broadcast, unicast, misroute with backpressure; then two reads
    vecs.push_back(mk(0, 1, 16'hFF01, 0, 0,  1, 16'hFF01, 1, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0203, 0, 0,  1, 16'hFF01, 2, 0, 0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0104, 0, 0,  1, 16'hFF01, 2, 0, 0, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0,  1, 16'h0203, 1, 0, 0, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0,  0, 16'h0000, 0, 0, 1, 0, 3, 0, 1));
    // 3: six pushes into depth 4, last two dropped
    vecs.push_back(mk(0, 1, 16'h0210, 0, 0,  1, 16'h0210, 1, 0, 0, 0, 4, 0, 1));
    vecs.push_back(mk(0, 1, 16'h0211, 0, 0,  1, 16'h0210, 2, 0, 0, 0, 5, 0, 1));
    vecs.push_back(mk(0, 1, 16'h0212, 0, 0,  1, 16'h0210, 3, 0, 0, 0, 6, 0, 1));
    vecs.push_back(mk(0, 1, 16'h0213, 0, 0,  1, 16'h0210, 4, 1, 0, 0, 7, 0, 1));
    vecs.push_back(mk(0, 1, 16'h0214, 0, 0,  1, 16'h0210, 4, 1, 0, 1, 7, 1, 1));
    vecs.push_back(mk(0, 1, 16'h0215, 0, 0,  1, 16'h0210, 4, 1, 0, 1, 7, 2, 1));
    // 4: full + read + push in the same cycle; then drain to the new tail
    vecs.push_back(mk(0, 1, 16'h02EE, 1, 0,  1, 16'h0211, 4, 1, 0, 1, 8, 2, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0,  1, 16'h0212, 3, 0, 0, 1, 8, 2, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0,  1, 16'h0213, 2, 0, 0, 1, 8, 2, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0,  1, 16'h02EE, 1, 0, 0, 1, 8, 2, 1));
    // refill to full
    vecs.push_back(mk(0, 1, 16'h0220, 0, 0,  1, 16'h02EE, 2, 0, 0, 1, 9, 2, 1));
    vecs.push_back(mk(0, 1, 16'h0221, 0, 0,  1, 16'h02EE, 3, 0, 0, 1, 10, 2, 1));
    vecs.push_back(mk(0, 1, 16'h0222, 0, 0,  1, 16'h02EE, 4, 1, 0, 1, 11, 2, 1));
    // 5: clr_stat together with a dropped push
    vecs.push_back(mk(0, 1, 16'h0223, 0, 1,  1, 16'h02EE, 4, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0,  1, 16'h02EE, 4, 1, 0, 0, 0, 0, 0));
    // 6: bring to 3 entries, then reset with push
    vecs.push_back(mk(0, 1, 16'h0224, 1, 0,  1, 16'h0220, 4, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0,  1, 16'h0221, 3, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0230, 0, 0,  0, 16'h0000, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0,  0, 16'h0000, 0, 0, 1, 0, 0, 0, 0));
    // post-reset: broadcast accepted, misroute counted, clear beats misroute
    vecs.push_back(mk(0, 1, 16'hFF55, 0, 0,  1, 16'hFF55, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0355, 0, 0,  1, 16'hFF55, 1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 16'h0077, 0, 1,  1, 16'hFF55, 1, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].push, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      @(negedge clk);
      expect_all($sformatf("v%0d", i), vecs[i].rv, vecs[i].rdat, vecs[i].cnt,
                 vecs[i].full, vecs[i].empty, vecs[i].ovf, vecs[i].st);
    end

    // Backpressure: head holds for several cycles.
    for (int k = 0; k < 3; k++)
      step($sformatf("hold%0d", k), 0, 0, 16'h0000, 0, 0,
           1, 16'hFF55, 1, 0, 0, 0, 0, 0, 0);
    // Pop the last entry, then keep rd_ready high while empty.
    step("pop_last",  0, 0, 16'h0000, 1, 0,  0, 16'h0000, 0, 0, 1, 0, 0, 0, 0);
    step("underflow0", 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0);
    step("underflow1", 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0);
    // Push into empty with rd_ready high: no pop yet, packet falls through.
    step("fwft",      0, 1, 16'h02AA, 1, 0,  1, 16'h02AA, 1, 0, 0, 0, 1, 0, 0);
    // Simultaneous push and pop at one entry: count stays 1, new head.
    step("push_pop",  0, 1, 16'h02BB, 1, 0,  1, 16'h02BB, 1, 0, 0, 0, 2, 0, 0);
    step("drain",     0, 0, 16'h0000, 1, 0,  0, 16'h0000, 0, 0, 1, 0, 2, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
